// File: rtl/quiz_pkg.sv
// Shared types and constants for the full-adder quiz scorer slice.
// Every rtl file imports this package.
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int VEC_W      = 3;
  localparam int NUM_COMBOS = 8;

endpackage

// File: rtl/adder_quiz_scorer_if.sv
// Paired reference/student answer bus into the scorer and the result bus out of it.
// The master side drives vectors and answers; the slave side is the scorer.
interface adder_quiz_scorer_if #(
  parameter int CNT_W = 8
);
  import quiz_pkg::*;

  logic                  start;
  logic                  vec_valid;
  logic                  a;
  logic                  b;
  logic                  cin;
  logic                  out_true;
  logic                  cout_true;
  logic                  out_test;
  logic                  cout_test;

  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CNT_W-1:0]      correct_cnt;
  logic [CNT_W-1:0]      error_cnt;
  logic                  first_err_valid;
  logic [VEC_W-1:0]      first_err_vec;
  logic [CNT_W-1:0]      first_err_idx;
  logic [NUM_COMBOS-1:0] combo_seen;
  logic                  coverage_full;

  modport master (
    output start, vec_valid, a, b, cin, out_true, cout_true, out_test, cout_test,
    input  busy, done, pass, correct_cnt, error_cnt, first_err_valid,
           first_err_vec, first_err_idx, combo_seen, coverage_full
  );

  modport slave (
    input  start, vec_valid, a, b, cin, out_true, cout_true, out_test, cout_test,
    output busy, done, pass, correct_cnt, error_cnt, first_err_valid,
           first_err_vec, first_err_idx, combo_seen, coverage_full
  );

endinterface

// File: rtl/quiz_first_err_capture.sv
// Holds the vector and index of the first mismatch of a session.
// Once valid, later captures are ignored until the next clear.
module quiz_first_err_capture
  import quiz_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_capture,
  input  logic [VEC_W-1:0] i_vec,
  input  logic [CNT_W-1:0] i_idx,
  output logic             o_valid,
  output logic [VEC_W-1:0] o_vec,
  output logic [CNT_W-1:0] o_idx
);

  logic             r_valid;
  logic [VEC_W-1:0] r_vec;
  logic [CNT_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_idx   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_vec   <= '0;
      r_idx   <= '0;
    end else if (i_capture && !r_valid) begin
      r_valid <= 1'b1;
      r_vec   <= i_vec;
      r_idx   <= i_idx;
    end
  end

  assign o_valid = r_valid;
  assign o_vec   = r_vec;
  assign o_idx   = r_idx;

endmodule

// File: rtl/adder_quiz_scorer.sv
// Scores a session of NUM_VECTORS sampled full-adder answers and issues a
// registered pass/fail verdict with first-error capture and combo coverage.
module adder_quiz_scorer
  import quiz_pkg::*;
#(
  parameter int NUM_VECTORS = 16,
  parameter int PASS_MIN    = 16,
  parameter int CNT_W       = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  adder_quiz_scorer_if.slave bus
);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [CNT_W-1:0]      r_correctCnt;
  logic [CNT_W-1:0]      r_errorCnt;
  logic [CNT_W-1:0]      r_vecIdx;
  logic [NUM_COMBOS-1:0] r_comboSeen;

  logic                  w_match;
  logic [VEC_W-1:0]      w_vec;
  logic                  w_sample;
  logic                  w_sessionStart;
  logic [CNT_W-1:0]      w_correctNext;
  logic                  w_lastSample;
  logic                  w_firstErrValid;
  logic [VEC_W-1:0]      w_firstErrVec;
  logic [CNT_W-1:0]      w_firstErrIdx;

  assign w_match        = (bus.out_true == bus.out_test) && (bus.cout_true == bus.cout_test);
  assign w_vec          = {bus.a, bus.b, bus.cin};
  assign w_sample       = (r_state == RUN) && bus.vec_valid;
  assign w_sessionStart = bus.start && (r_state != RUN);
  assign w_correctNext  = r_correctCnt + {{(CNT_W-1){1'b0}}, w_match};
  assign w_lastSample   = (r_vecIdx == CNT_W'(NUM_VECTORS - 1));

  // The verdict uses the post-increment correct count so it lands with done.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_correctCnt <= '0;
      r_errorCnt   <= '0;
      r_vecIdx     <= '0;
      r_comboSeen  <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state      <= RUN;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_correctCnt <= '0;
            r_errorCnt   <= '0;
            r_vecIdx     <= '0;
            r_comboSeen  <= '0;
          end
        end
        RUN: begin
          if (bus.vec_valid) begin
            if (w_match) r_correctCnt <= w_correctNext;
            else         r_errorCnt   <= r_errorCnt + 1'b1;
            r_comboSeen[w_vec] <= 1'b1;
            r_vecIdx           <= r_vecIdx + 1'b1;
            if (w_lastSample) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_correctNext >= CNT_W'(PASS_MIN));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  quiz_first_err_capture #(
    .CNT_W(CNT_W)
  ) u_firstErr (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .i_clear  (w_sessionStart),
    .i_capture(w_sample && !w_match),
    .i_vec    (w_vec),
    .i_idx    (r_vecIdx),
    .o_valid  (w_firstErrValid),
    .o_vec    (w_firstErrVec),
    .o_idx    (w_firstErrIdx)
  );

  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.correct_cnt     = r_correctCnt;
  assign bus.error_cnt       = r_errorCnt;
  assign bus.first_err_valid = w_firstErrValid;
  assign bus.first_err_vec   = w_firstErrVec;
  assign bus.first_err_idx   = w_firstErrIdx;
  assign bus.combo_seen      = r_comboSeen;
  assign bus.coverage_full   = (r_comboSeen == 8'hFF);

endmodule

// File: tb/tb_adder_quiz_scorer.sv
// Directed, table-driven bench for adder_quiz_scorer; a second instance with
// PASS_MIN=12 shares the stimulus to check the verdict threshold.
module tb_adder_quiz_scorer;

  logic sys_clk;
  logic sys_rst;
  int   compared;
  int   mismatched;

  adder_quiz_scorer_if #(.CNT_W(8)) bus16 ();
  adder_quiz_scorer_if #(.CNT_W(8)) bus12 ();

  assign bus12.start     = bus16.start;
  assign bus12.vec_valid = bus16.vec_valid;
  assign bus12.a         = bus16.a;
  assign bus12.b         = bus16.b;
  assign bus12.cin       = bus16.cin;
  assign bus12.out_true  = bus16.out_true;
  assign bus12.cout_true = bus16.cout_true;
  assign bus12.out_test  = bus16.out_test;
  assign bus12.cout_test = bus16.cout_test;

  adder_quiz_scorer #(.NUM_VECTORS(16), .PASS_MIN(16), .CNT_W(8)) dut16 (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus16)
  );

  adder_quiz_scorer #(.NUM_VECTORS(16), .PASS_MIN(12), .CNT_W(8)) dut12 (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus12)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] errSum;
    logic [15:0] errCarry;
    int          nCombo;
    int          gap;
    int          expCorrect;
    int          expError;
    logic        expFirstValid;
    int          expFirstIdx;
    logic [2:0]  expFirstVec;
    logic [7:0]  expCombo;
    logic        expPass16;
    logic        expPass12;
  } sessionRec_t;

  sessionRec_t sessions[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic flipSum, input logic flipCarry);
    logic s;
    logic c;
    s = v[2] ^ v[1] ^ v[0];
    c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    bus16.a         = v[2];
    bus16.b         = v[1];
    bus16.cin       = v[0];
    bus16.out_true  = s;
    bus16.cout_true = c;
    bus16.out_test  = s ^ flipSum;
    bus16.cout_test = c ^ flipCarry;
    bus16.vec_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    bus16.vec_valid = 1'b0;
  endtask

  task automatic pulseStart();
    bus16.start = 1'b1;
    @(posedge sys_clk);
    #1;
    bus16.start = 1'b0;
  endtask

  task automatic runSession(input int r);
    sessionRec_t rec;
    logic [2:0]  v;
    rec = sessions[r];
    pulseStart();
    checkOutput($sformatf("s%0d start busy", r), 32'(bus16.busy), 32'd1);
    checkOutput($sformatf("s%0d start done", r), 32'(bus16.done), 32'd0);
    checkOutput($sformatf("s%0d start pass", r), 32'(bus16.pass), 32'd0);
    checkOutput($sformatf("s%0d start correct", r), 32'(bus16.correct_cnt), 32'd0);
    checkOutput($sformatf("s%0d start combo", r), 32'(bus16.combo_seen), 32'd0);
    for (int i = 0; i < 16; i++) begin
      v = 3'(i % rec.nCombo);
      applyStimulus(v, rec.errSum[i], rec.errCarry[i]);
      if (i == 14) begin
        checkOutput($sformatf("s%0d done before last", r), 32'(bus16.done), 32'd0);
        checkOutput($sformatf("s%0d busy before last", r), 32'(bus16.busy), 32'd1);
      end
      if (i < 15) begin
        for (int g = 0; g < rec.gap; g++) begin
          bus16.start = (g == 0);
          @(posedge sys_clk);
          #1;
          bus16.start = 1'b0;
        end
      end
    end
    checkOutput($sformatf("s%0d done", r), 32'(bus16.done), 32'd1);
    checkOutput($sformatf("s%0d busy", r), 32'(bus16.busy), 32'd0);
    checkOutput($sformatf("s%0d correct_cnt", r), 32'(bus16.correct_cnt), 32'(rec.expCorrect));
    checkOutput($sformatf("s%0d error_cnt", r), 32'(bus16.error_cnt), 32'(rec.expError));
    checkOutput($sformatf("s%0d first_err_valid", r), 32'(bus16.first_err_valid), 32'(rec.expFirstValid));
    checkOutput($sformatf("s%0d first_err_idx", r), 32'(bus16.first_err_idx), 32'(rec.expFirstIdx));
    checkOutput($sformatf("s%0d first_err_vec", r), 32'(bus16.first_err_vec), 32'(rec.expFirstVec));
    checkOutput($sformatf("s%0d combo_seen", r), 32'(bus16.combo_seen), 32'(rec.expCombo));
    checkOutput($sformatf("s%0d coverage_full", r), 32'(bus16.coverage_full), 32'(rec.expCombo == 8'hFF));
    checkOutput($sformatf("s%0d pass16", r), 32'(bus16.pass), 32'(rec.expPass16));
    checkOutput($sformatf("s%0d pass12", r), 32'(bus12.pass), 32'(rec.expPass12));
    // vec_valid while DONE must not disturb the held results
    applyStimulus(3'b111, 1'b1, 1'b1);
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkOutput($sformatf("s%0d held correct", r), 32'(bus16.correct_cnt), 32'(rec.expCorrect));
    checkOutput($sformatf("s%0d held error", r), 32'(bus16.error_cnt), 32'(rec.expError));
    checkOutput($sformatf("s%0d held done", r), 32'(bus16.done), 32'd1);
    checkOutput($sformatf("s%0d held pass16", r), 32'(bus16.pass), 32'(rec.expPass16));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    sessions[0] = '{16'h0000, 16'h0000, 8, 0, 16, 0, 1'b0, 0,  3'b000, 8'hFF, 1'b1, 1'b1};
    sessions[1] = '{16'h0000, 16'h0020, 8, 0, 15, 1, 1'b1, 5,  3'b101, 8'hFF, 1'b0, 1'b1};
    sessions[2] = '{16'h0284, 16'h0000, 8, 0, 13, 3, 1'b1, 2,  3'b010, 8'hFF, 1'b0, 1'b1};
    sessions[3] = '{16'h000F, 16'h000F, 8, 0, 12, 4, 1'b1, 0,  3'b000, 8'hFF, 1'b0, 1'b1};
    sessions[4] = '{16'h001F, 16'h0000, 8, 0, 11, 5, 1'b1, 0,  3'b000, 8'hFF, 1'b0, 1'b0};
    sessions[5] = '{16'h0000, 16'h8000, 8, 2, 15, 1, 1'b1, 15, 3'b111, 8'hFF, 1'b0, 1'b1};
    sessions[6] = '{16'h0020, 16'h0000, 3, 0, 15, 1, 1'b1, 5,  3'b010, 8'h07, 1'b0, 1'b1};

    sys_rst         = 1'b1;
    bus16.start     = 1'b0;
    bus16.vec_valid = 1'b0;
    bus16.a         = 1'b0;
    bus16.b         = 1'b0;
    bus16.cin       = 1'b0;
    bus16.out_true  = 1'b0;
    bus16.cout_true = 1'b0;
    bus16.out_test  = 1'b0;
    bus16.cout_test = 1'b0;
    repeat (2) @(posedge sys_clk);
    #3;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    checkOutput("reset busy", 32'(bus16.busy), 32'd0);
    checkOutput("reset done", 32'(bus16.done), 32'd0);
    checkOutput("reset pass", 32'(bus16.pass), 32'd0);
    checkOutput("reset correct", 32'(bus16.correct_cnt), 32'd0);
    checkOutput("reset error", 32'(bus16.error_cnt), 32'd0);
    checkOutput("reset first_err_valid", 32'(bus16.first_err_valid), 32'd0);
    checkOutput("reset combo", 32'(bus16.combo_seen), 32'd0);

    // vec_valid in IDLE is ignored
    applyStimulus(3'b011, 1'b1, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("idle correct", 32'(bus16.correct_cnt), 32'd0);
    checkOutput("idle error", 32'(bus16.error_cnt), 32'd0);
    checkOutput("idle combo", 32'(bus16.combo_seen), 32'd0);
    checkOutput("idle first_err_valid", 32'(bus16.first_err_valid), 32'd0);
    checkOutput("idle busy", 32'(bus16.busy), 32'd0);

    for (int r = 0; r < 7; r++) begin
      $display("[TB] session %0d", r);
      runSession(r);
    end

    // Asynchronous reset part-way through a session
    $display("[TB] reset mid-run");
    pulseStart();
    for (int i = 0; i < 7; i++) applyStimulus(3'(i), 1'b0, (i == 3));
    checkOutput("midrun correct", 32'(bus16.correct_cnt), 32'd6);
    checkOutput("midrun error", 32'(bus16.error_cnt), 32'd1);
    checkOutput("midrun first_err_idx", 32'(bus16.first_err_idx), 32'd3);
    #3;
    sys_rst = 1'b1;
    #1;
    checkOutput("async rst busy", 32'(bus16.busy), 32'd0);
    checkOutput("async rst correct", 32'(bus16.correct_cnt), 32'd0);
    checkOutput("async rst error", 32'(bus16.error_cnt), 32'd0);
    checkOutput("async rst first_err_valid", 32'(bus16.first_err_valid), 32'd0);
    checkOutput("async rst first_err_idx", 32'(bus16.first_err_idx), 32'd0);
    checkOutput("async rst combo", 32'(bus16.combo_seen), 32'd0);
    #2;
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    runSession(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adder_quiz_scorer.md
Name: adder_quiz_scorer

Overview:
- Downstream consumer of the full-adder quiz tester's paired outputs (reference answer vs. student answer).
- Runs a scoring session of NUM_VECTORS sampled vectors and counts correct and incorrect answers.
- Captures the first failing vector and tracks which of the 8 {a,b,cin} combinations were exercised.
- Issues a registered pass/fail verdict for the FPGA quiz-tester top level.

Parameters:
- NUM_VECTORS, 16: vectors scored per session; must be >= 1.
- PASS_MIN, 16: minimum correct count for pass; must be <= NUM_VECTORS.
- CNT_W, 8: counter/index width; must satisfy 2^CNT_W > NUM_VECTORS.

Ports:
- sys_clk  in  1  single clock, rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a session.
- vec_valid  in  1  current vector and answers are stable; sample this cycle.
- a  in  1  stimulus operand.
- b  in  1  stimulus operand.
- cin  in  1  stimulus carry-in.
- out_true  in  1  reference sum.
- cout_true  in  1  reference carry.
- out_test  in  1  student sum.
- cout_test  in  1  student carry.
- busy  out  1  session in progress.
- done  out  1  session finished; held until next start.
- pass  out  1  verdict; valid while done=1.
- correct_cnt  out  CNT_W  vectors with both outputs matching.
- error_cnt  out  CNT_W  vectors with any mismatch.
- first_err_valid  out  1  a mismatch has been captured this session.
- first_err_vec  out  3  {a,b,cin} of the first mismatch.
- first_err_idx  out  CNT_W  vector index (0-based) of the first mismatch.
- combo_seen  out  8  bit {a,b,cin} set once that combination is sampled.
- coverage_full  out  1  combo_seen == 8'hFF.

Behaviour:
- Reset, asynchronous, any state: state=IDLE. busy, done, pass, first_err_valid = 0. correct_cnt, error_cnt, first_err_vec, first_err_idx, combo_seen = 0. Internal vec_idx = 0. An in-progress session is abandoned with no partial verdict.
- Match is combinational: match = (out_true==out_test) && (cout_true==cout_test).
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: clear counters, capture regs, combo_seen and vec_idx; go to RUN.
  - RUN: busy=1. start is ignored.
  - RUN, vec_valid=1: on the same edge, increment correct_cnt if match, else error_cnt. Set combo_seen[{a,b,cin}]. Increment vec_idx.
  - RUN, vec_valid=1 and match=0 and first_err_valid=0: latch first_err_vec={a,b,cin} and first_err_idx=vec_idx; set first_err_valid. Later mismatches do not overwrite.
  - RUN, vec_valid=1 and vec_idx==NUM_VECTORS-1: go to DONE at that edge. done=1 and busy=0 the next cycle. pass = (final correct_cnt >= PASS_MIN), computed from the post-increment value and registered together with done.
  - DONE: all results held. vec_valid ignored. start=1 clears everything and re-enters RUN, with done and pass dropping to 0 on that edge.
- vec_valid in IDLE or DONE has no effect on any output.
- Latency: counters and combo_seen reflect a sampled vector one cycle after its vec_valid. done rises one cycle after the last sample.
- Counters never wrap (bounded by NUM_VECTORS < 2^CNT_W). correct_cnt + error_cnt == vec_idx at all times in RUN and DONE.
- Back-to-back vec_valid on every cycle is legal. NUM_VECTORS=1 means the first sample completes the session.
- coverage_full is combinational from combo_seen.

Decomposition:
- Shared package quiz_pkg: FSM state encodings (IDLE/RUN/DONE, 2 bits), VEC_W=3, NUM_COMBOS=8.
- One natural sub-module, quiz_first_err_capture: first-mismatch latch with clear, capture-enable, vector and index inputs.

Test Plan:
- All-correct session: start, then 16 vectors with test==true covering all 8 combos twice -> done=1 one cycle after the 16th sample; correct_cnt=16, error_cnt=0, pass=1, first_err_valid=0, combo_seen=8'hFF.
- Single error: mismatch injected at vector 5 with {a,b,cin}=3'b101 (cout_test flipped) -> error_cnt=1, correct_cnt=15, first_err_idx=5, first_err_vec=3'b101, pass=0 (PASS_MIN=16).
- Multiple errors: mismatches at indices 2, 7 and 9 -> first_err_idx=2 held, error_cnt=3; with PASS_MIN=12 -> pass=1.
- Gapped valid: vec_valid asserted on every third cycle; extra start pulses mid-run; vec_valid pulses in IDLE and DONE -> counts change only on RUN samples, start ignored in RUN, done timing relative to the 16th sample.
- Reset mid-run: sys_rst asserted asynchronously after 7 samples -> all outputs 0 immediately; a new start runs a clean 16-vector session.
- Restart from DONE: start pulse while done=1 -> done and pass drop the next cycle; counters=0, combo_seen=0, busy=1.
